// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART Tx FIFO write port among N_REQ producers.
// The grant is held until the last byte; a stalled owner is force-released after TIMEOUT idle cycles.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_wr_data,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state, state_nx;
    logic [GW-1:0]   rr_ptr, rr_ptr_nx;
    logic [GW-1:0]   grant_nx;
    logic [CW-1:0]   idle_cnt, idle_cnt_nx;
    logic            terr_nx;
    logic [GW-1:0]   pick;
    logic            found;
    int unsigned     idx;

    // Reset is active-high on rst_n.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state       <= IDLE;
            rr_ptr      <= GW'(N_REQ - 1);
            grant_id    <= '0;
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            rr_ptr      <= rr_ptr_nx;
            grant_id    <= grant_nx;
            idle_cnt    <= idle_cnt_nx;
            timeout_err <= terr_nx;
        end
    end

    // First valid requester after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % N_REQ;
            if (!found && req_valid[idx[GW-1:0]]) begin
                found = 1'b1;
                pick  = idx[GW-1:0];
            end
        end
    end

    always_comb begin
        state_nx    = state;
        rr_ptr_nx   = rr_ptr;
        grant_nx    = grant_id;
        idle_cnt_nx = idle_cnt;
        terr_nx     = 1'b0;
        case (state)
            IDLE: begin
                idle_cnt_nx = '0;
                if (found) begin
                    state_nx = LOCKED;
                    grant_nx = pick;
                end
            end
            LOCKED: begin
                if (fifo_wr_en) begin
                    idle_cnt_nx = '0;
                    if (req_last[grant_id]) begin
                        state_nx  = IDLE;
                        rr_ptr_nx = grant_id;
                    end
                end else if (!req_valid[grant_id]) begin
                    // Stalls on fifo_full with valid held neither count nor clear.
                    if (idle_cnt == CW'(TIMEOUT - 1)) begin
                        state_nx    = IDLE;
                        rr_ptr_nx   = grant_id;
                        terr_nx     = 1'b1;
                        idle_cnt_nx = '0;
                    end else begin
                        idle_cnt_nx = idle_cnt + CW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state == LOCKED);
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        if (busy) begin
            req_ready[grant_id] = !fifo_full;
            fifo_wr_en          = req_valid[grant_id] && !fifo_full;
            if (fifo_wr_en) begin
                fifo_wr_data = req_data[grant_id*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle-level reference model compared every cycle plus directed literal checks.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           fifo_full;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_wr_data;
    logic [1:0]     grant_id;
    logic           busy;
    logic           timeout_err;

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .grant_id(grant_id),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {int cyc; int g; int d;} wr_t;
    wr_t wr_log[$];
    int  terr_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return 0;
    endfunction

    // Reference model: packet owner, release pointer and idle-run length as plain integers.
    bit m_busy, m_terr;
    int m_own, m_ptr, m_idle;

    initial begin
        logic [N-1:0] e_ready;
        logic         e_wr;
        logic [W-1:0] e_data;
        m_busy = 0; m_terr = 0; m_own = 0; m_ptr = N - 1; m_idle = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                m_busy = 0; m_terr = 0; m_own = 0; m_ptr = N - 1; m_idle = 0;
            end
            e_ready = (m_busy && !fifo_full) ? N'(1 << m_own) : '0;
            e_wr    = m_busy && req_valid[m_own] && !fifo_full;
            e_data  = e_wr ? req_data[m_own*W +: W] : '0;
            chk("busy", 32'(busy), 32'(m_busy));
            chk("timeout_err", 32'(timeout_err), 32'(m_terr));
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wr));
            chk("fifo_wr_data", 32'(fifo_wr_data), 32'(e_data));
            if (m_busy) chk("grant_id", 32'(grant_id), 32'(m_own));
            if (fifo_wr_en === 1'b1) wr_log.push_back('{cyc, int'(grant_id), int'(fifo_wr_data)});
            if (timeout_err === 1'b1) terr_log.push_back(cyc);
            if (!rst_n) begin
                m_terr = 0;
                if (!m_busy) begin
                    m_idle = 0;
                    if (req_valid != 0) begin
                        m_own  = rr_pick(m_ptr, req_valid);
                        m_busy = 1;
                    end
                end else if (e_wr) begin
                    m_idle = 0;
                    if (req_last[m_own]) begin m_busy = 0; m_ptr = m_own; end
                end else if (!req_valid[m_own]) begin
                    m_idle++;
                    if (m_idle == TO) begin m_busy = 0; m_ptr = m_own; m_terr = 1; m_idle = 0; end
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic set_byte(input int i, input logic [W-1:0] b, input logic last);
        req_data[i*W +: W] = b;
        req_last[i]        = last;
    endtask

    initial begin
        int b, t, req_cyc, drop_cyc;
        rst_n = 1'b1; req_valid = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;
        tick(3);
        rst_n = 1'b0;
        tick(1);

        // 1: single 3-byte packet from requester 2
        b = wr_log.size();
        set_byte(2, 8'h41, 1'b0); req_valid = 4'b0100; req_cyc = cyc + 1;
        tick(2); set_byte(2, 8'h42, 1'b0);
        tick(1); set_byte(2, 8'h43, 1'b1);
        tick(1); req_valid = '0; req_last = '0;
        tick(2);
        chk("t1_count", 32'(wr_log.size() - b), 32'd3);
        if (wr_log.size() - b >= 3) begin
            chk("t1_latency", 32'(wr_log[b].cyc - req_cyc), 32'd1);
            chk("t1_grant", 32'(wr_log[b].g), 32'd2);
            chk("t1_d0", 32'(wr_log[b].d), 32'h41);
            chk("t1_d1", 32'(wr_log[b+1].d), 32'h42);
            chk("t1_d2", 32'(wr_log[b+2].d), 32'h43);
            chk("t1_consec", 32'(wr_log[b+2].cyc - wr_log[b].cyc), 32'd2);
        end

        // 2: all four sending 1-byte packets from reset
        rst_n = 1'b1; tick(2); rst_n = 1'b0;
        b = wr_log.size();
        for (int i = 0; i < N; i++) set_byte(i, 8'(8'hA0 + i), 1'b1);
        req_valid = 4'b1111;
        tick(10);
        req_valid = '0; req_last = '0;
        tick(2);
        chk("t2_count", 32'(wr_log.size() - b), 32'd5);
        if (wr_log.size() - b >= 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("t2_grant", 32'(wr_log[b+i].g), 32'(i % N));
                chk("t2_data", 32'(wr_log[b+i].d), 32'(8'hA0 + (i % N)));
                if (i > 0) chk("t2_gap", 32'(wr_log[b+i].cyc - wr_log[b+i-1].cyc), 32'd2);
            end
        end

        // 3: fifo_full stall longer than TIMEOUT with valid held
        b = wr_log.size(); t = terr_log.size();
        set_byte(1, 8'h51, 1'b0); req_valid = 4'b0010;
        tick(2); set_byte(1, 8'h52, 1'b0); fifo_full = 1'b1;
        tick(20); fifo_full = 1'b0; drop_cyc = cyc + 1;
        tick(1); set_byte(1, 8'h53, 1'b1);
        tick(1); req_valid = '0; req_last = '0;
        tick(2);
        chk("t3_count", 32'(wr_log.size() - b), 32'd3);
        chk("t3_no_timeout", 32'(terr_log.size() - t), 32'd0);
        if (wr_log.size() - b >= 3) begin
            chk("t3_grant", 32'(wr_log[b].g), 32'd1);
            chk("t3_d1", 32'(wr_log[b+1].d), 32'h52);
            chk("t3_d1_cyc", 32'(wr_log[b+1].cyc), 32'(drop_cyc));
            chk("t3_d2", 32'(wr_log[b+2].d), 32'h53);
        end

        // 4: owner 2 goes silent after one byte, requester 3 waiting
        b = wr_log.size(); t = terr_log.size();
        set_byte(2, 8'h61, 1'b0); set_byte(3, 8'h71, 1'b1); req_valid = 4'b1100;
        tick(2); req_valid = 4'b1000;
        tick(10); req_valid = '0; req_last = '0;
        tick(2);
        chk("t4_pulses", 32'(terr_log.size() - t), 32'd1);
        chk("t4_count", 32'(wr_log.size() - b), 32'd2);
        if (terr_log.size() - t >= 1 && wr_log.size() - b >= 2) begin
            chk("t4_first", 32'(wr_log[b].g * 256 + wr_log[b].d), 32'h261);
            // 8 idle cycles after the transfer, pulse appears after the release edge
            chk("t4_pulse_cyc", 32'(terr_log[t] - wr_log[b].cyc), 32'd9);
            chk("t4_next", 32'(wr_log[b+1].g * 256 + wr_log[b+1].d), 32'h371);
            chk("t4_next_cyc", 32'(wr_log[b+1].cyc - terr_log[t]), 32'd1);
        end

        // 5: reset after 2 of 5 bytes
        b = wr_log.size();
        set_byte(1, 8'h81, 1'b0); req_valid = 4'b0010;
        tick(2); set_byte(1, 8'h82, 1'b0);
        tick(1); set_byte(1, 8'h83, 1'b0);
        chk("t5_pre_count", 32'(wr_log.size() - b), 32'd2);
        rst_n = 1'b1;
        #1;
        chk("t5_wr_en_now", 32'(fifo_wr_en), 32'd0);
        chk("t5_busy_now", 32'(busy), 32'd0);
        tick(2);
        b = wr_log.size();
        set_byte(0, 8'h90, 1'b1); set_byte(1, 8'h91, 1'b1); req_valid = 4'b0011;
        rst_n = 1'b0;
        tick(4); req_valid = '0; req_last = '0;
        tick(2);
        chk("t5_count", 32'(wr_log.size() - b), 32'd2);
        if (wr_log.size() - b >= 2) begin
            chk("t5_first", 32'(wr_log[b].g * 256 + wr_log[b].d), 32'h090);
            chk("t5_second", 32'(wr_log[b+1].g * 256 + wr_log[b+1].d), 32'h191);
        end

        // 6: non-owner 0 toggles last while requester 2 owns the port
        b = wr_log.size();
        set_byte(2, 8'hA1, 1'b0); set_byte(0, 8'hB0, 1'b0); req_valid = 4'b0101;
        tick(2); set_byte(2, 8'hA2, 1'b0); req_last[0] = 1'b1;
        tick(1); set_byte(2, 8'hA3, 1'b1); req_last[0] = 1'b0;
        tick(1); req_valid = 4'b0001; req_last = 4'b0001;
        tick(2); req_valid = '0; req_last = '0;
        tick(2);
        chk("t6_count", 32'(wr_log.size() - b), 32'd4);
        if (wr_log.size() - b >= 4) begin
            chk("t6_w0", 32'(wr_log[b].g * 256 + wr_log[b].d), 32'h2A1);
            chk("t6_w1", 32'(wr_log[b+1].g * 256 + wr_log[b+1].d), 32'h2A2);
            chk("t6_w2", 32'(wr_log[b+2].g * 256 + wr_log[b+2].d), 32'h2A3);
            chk("t6_w3", 32'(wr_log[b+3].g * 256 + wr_log[b+3].d), 32'h0B0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
